// File: rtl/serial_alu_seq.sv
// Bit-serial initiator for an external 1-bit ALU slice, LSB first.
// Optional zero output: define SERIAL_ALU_SEQ_ZERO_EN.
module serial_alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             flag,
  output logic             alu_a,
  output logic             alu_b,
  output logic             alu_c,
  output logic [1:0]       alu_ctr,
  input  logic             alu_d,
  input  logic             alu_e
`ifdef SERIAL_ALU_SEQ_ZERO_EN
  ,
  output logic             zero
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [1:0]       op_q;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             run;
  logic             chain;
  logic             last;
  logic [WIDTH-1:0] res_nx;

  // Only add and borrow-chain propagate e into the next bit.
  assign chain  = ~op_q[0];
  assign run    = (state == RUN);
  assign last   = (cnt == CW'(WIDTH - 1));
  assign res_nx = {alu_d, result[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      op_q   <= 2'b00;
      carry  <= 1'b0;
      cnt    <= '0;
      result <= '0;
      flag   <= 1'b0;
`ifdef SERIAL_ALU_SEQ_ZERO_EN
      zero   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= opa;
            b_sh  <= opb;
            op_q  <= op;
            carry <= 1'b0;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          result <= res_nx;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= chain & alu_e;
          cnt    <= cnt + CW'(1);
          if (last) begin
            flag  <= chain & alu_e;
            state <= DONE;
`ifdef SERIAL_ALU_SEQ_ZERO_EN
            zero  <= (res_nx == '0);
`endif
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign alu_a   = run & a_sh[0];
  assign alu_b   = run & b_sh[0];
  assign alu_c   = run & carry;
  assign alu_ctr = op_q;

endmodule
